vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_pattern_gen
// Parametrised VGA timing generator with runtime-selectable test patterns,
// optional two-field interlace and frame/field markers.
// Rev    : 1.0  initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int   H_DISP           = 640,
    parameter int   H_FPORCH         = 16,
    parameter int   H_SYNC           = 96,
    parameter int   H_BPORCH         = 48,
    parameter int   V_DISP           = 480,
    parameter int   V_FPORCH         = 10,
    parameter int   V_SYNC           = 2,
    parameter int   V_BPORCH         = 33,
    parameter logic HS_POLARITY      = 1'b0,
    parameter logic VS_POLARITY      = 1'b0,
    parameter logic FRAME_INTERLACED = 1'b0,
    parameter int   COLOR_BITS       = 4,
    parameter int   CNT_BITS         = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [2:0]            pattern_sel,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [CNT_BITS-1:0]   x,
    output logic [CNT_BITS-1:0]   y,
    output logic                  field,
    output logic                  frame_start,
    output logic [7:0]            frame_cnt,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b
);

    localparam int c_h_total = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int c_v_total = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int c_bar_w   = H_DISP / 8;

    localparam logic [CNT_BITS-1:0] c_h_last   = CNT_BITS'(c_h_total - 1);
    localparam logic [CNT_BITS-1:0] c_h_disp   = CNT_BITS'(H_DISP);
    localparam logic [CNT_BITS-1:0] c_x_last   = CNT_BITS'(H_DISP - 1);
    localparam logic [CNT_BITS-1:0] c_hs_start = CNT_BITS'(H_DISP + H_FPORCH);
    localparam logic [CNT_BITS-1:0] c_hs_end   = CNT_BITS'(H_DISP + H_FPORCH + H_SYNC);
    localparam logic [CNT_BITS-1:0] c_v_disp   = CNT_BITS'(V_DISP);
    localparam logic [CNT_BITS-1:0] c_y_last   = CNT_BITS'(V_DISP - 1);
    localparam logic [CNT_BITS-1:0] c_vs_start = CNT_BITS'(V_DISP + V_FPORCH);
    localparam logic [CNT_BITS-1:0] c_vs_end   = CNT_BITS'(V_DISP + V_FPORCH + V_SYNC);
    localparam logic [CNT_BITS-1:0] c_v_last0  = CNT_BITS'(c_v_total - 1);
    localparam logic [CNT_BITS-1:0] c_v_last1  = CNT_BITS'(c_v_total);
    localparam logic [CNT_BITS-1:0] c_bar_last = CNT_BITS'(c_bar_w - 1);
    localparam logic [CNT_BITS-1:0] c_one      = CNT_BITS'(1);
    localparam logic [COLOR_BITS-1:0] c_full   = '1;

    logic [CNT_BITS-1:0]   r_h_cnt;
    logic [CNT_BITS-1:0]   r_v_cnt;
    logic                  r_field;
    logic [2:0]            r_pattern;
    logic [2:0]            r_bar;
    logic [CNT_BITS-1:0]   r_bar_cnt;
    logic [7:0]            r_frame_cnt;

    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic [CNT_BITS-1:0]   r_x;
    logic [CNT_BITS-1:0]   r_y;
    logic                  r_field_q;
    logic                  r_frame_start;
    logic [7:0]            r_frame_cnt_q;
    logic [COLOR_BITS-1:0] r_red;
    logic [COLOR_BITS-1:0] r_grn;
    logic [COLOR_BITS-1:0] r_blu;

    logic                  w_h_wrap;
    logic                  w_v_wrap;
    logic                  w_h_act;
    logic                  w_de;
    logic                  w_hs_act;
    logic                  w_vs_act;
    logic                  w_origin;
    logic [2:0]            w_pat;
    logic [2:0]            w_code;
    logic [CNT_BITS-1:0]   w_y;
    logic [COLOR_BITS-1:0] w_red;
    logic [COLOR_BITS-1:0] w_grn;
    logic [COLOR_BITS-1:0] w_blu;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_v_wrap = (r_v_cnt == ((FRAME_INTERLACED && r_field) ? c_v_last1 : c_v_last0));
    assign w_h_act  = (r_h_cnt < c_h_disp);
    assign w_de     = w_h_act && (r_v_cnt < c_v_disp);
    assign w_hs_act = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_act = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    // The field's first pixel already uses the freshly selected pattern.
    assign w_pat    = w_origin ? pattern_sel : r_pattern;
    assign w_code   = 3'd7 - r_bar;
    assign w_y      = FRAME_INTERLACED ? {r_v_cnt[CNT_BITS-2:0], r_field} : r_v_cnt;

    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        if (w_de) begin
            case (w_pat)
                3'd0: begin
                    w_red = w_code[1] ? c_full : '0;
                    w_grn = w_code[2] ? c_full : '0;
                    w_blu = w_code[0] ? c_full : '0;
                end
                3'd1: begin
                    w_red = r_h_cnt[COLOR_BITS+3:4];
                    w_grn = r_h_cnt[COLOR_BITS+3:4];
                    w_blu = r_h_cnt[COLOR_BITS+3:4];
                end
                3'd2: begin
                    if (r_h_cnt[3] ^ w_y[3]) begin
                        w_red = c_full;
                        w_grn = c_full;
                        w_blu = c_full;
                    end
                end
                3'd3: begin
                    if ((r_h_cnt[3:0] == 4'd0) || (w_y[3:0] == 4'd0) ||
                        (r_h_cnt == c_x_last) || (r_v_cnt == c_y_last)) begin
                        w_red = c_full;
                        w_grn = c_full;
                        w_blu = c_full;
                    end
                end
                3'd4: begin
                    w_red = r_frame_cnt[COLOR_BITS-1:0];
                    w_grn = r_frame_cnt[COLOR_BITS-1:0];
                    w_blu = r_frame_cnt[COLOR_BITS-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_field       <= 1'b0;
            r_pattern     <= 3'd0;
            r_bar         <= 3'd0;
            r_bar_cnt     <= '0;
            r_frame_cnt   <= 8'd0;
            r_hsync       <= ~HS_POLARITY;
            r_vsync       <= ~VS_POLARITY;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_field_q     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt_q <= 8'd0;
            r_red         <= '0;
            r_grn         <= '0;
            r_blu         <= '0;
        end else if (en) begin
            r_hsync       <= w_hs_act ? HS_POLARITY : ~HS_POLARITY;
            r_vsync       <= w_vs_act ? VS_POLARITY : ~VS_POLARITY;
            r_de          <= w_de;
            r_field_q     <= r_field;
            r_frame_start <= w_de && w_origin;
            r_frame_cnt_q <= r_frame_cnt;
            r_red         <= w_red;
            r_grn         <= w_grn;
            r_blu         <= w_blu;
            if (w_de) begin
                r_x <= r_h_cnt;
                r_y <= w_y;
            end
            if (w_origin) begin
                r_pattern <= pattern_sel;
            end

            if (w_h_wrap) begin
                r_h_cnt   <= '0;
                r_bar     <= 3'd0;
                r_bar_cnt <= '0;
                if (w_v_wrap) begin
                    r_v_cnt <= '0;
                    r_field <= FRAME_INTERLACED & ~r_field;
                    if (!FRAME_INTERLACED || r_field) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end else begin
                    r_v_cnt <= r_v_cnt + c_one;
                end
            end else begin
                r_h_cnt <= r_h_cnt + c_one;
                // Bar 7 absorbs any remainder pixels, so it never advances.
                if (w_h_act && (r_bar != 3'd7)) begin
                    if (r_bar_cnt == c_bar_last) begin
                        r_bar     <= r_bar + 3'd1;
                        r_bar_cnt <= '0;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + c_one;
                    end
                end
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign field       = r_field_q;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt_q;
    assign vga_r       = r_red;
    assign vga_g       = r_grn;
    assign vga_b       = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_pattern_gen
// Scoreboard bench for vga_pattern_gen: three small-mode builds (A: base,
// B: 20-pixel lines, C: interlaced with inverted sync polarity).
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_pattern_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        fld;
        logic        fs;
        logic [7:0]  fc;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } ovec_t;

    typedef struct packed {
        ovec_t a;
        ovec_t b;
        ovec_t c;
    } trip_t;

    localparam int HF = 2, HSW = 3, HB = 3;
    localparam int VD = 8, VF = 1, VSW = 2, VB = 1;

    int   hd  [3] = '{16, 20, 16};
    logic pol [3] = '{1'b0, 1'b0, 1'b1};
    logic il  [3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] pattern_sel = 3'd0;

    logic hs_a, vs_a, de_a, fld_a, fs_a;
    logic hs_b, vs_b, de_b, fld_b, fs_b;
    logic hs_c, vs_c, de_c, fld_c, fs_c;
    logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [7:0]  fc_a, fc_b, fc_c;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

    vga_pattern_gen #(
        .H_DISP(16), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
        .V_DISP(8), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
        .HS_POLARITY(1'b0), .VS_POLARITY(1'b0), .FRAME_INTERLACED(1'b0),
        .COLOR_BITS(4), .CNT_BITS(12)
    ) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .pattern_sel(pattern_sel),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a), .field(fld_a),
        .frame_start(fs_a), .frame_cnt(fc_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_pattern_gen #(
        .H_DISP(20), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
        .V_DISP(8), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
        .HS_POLARITY(1'b0), .VS_POLARITY(1'b0), .FRAME_INTERLACED(1'b0),
        .COLOR_BITS(4), .CNT_BITS(12)
    ) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .pattern_sel(pattern_sel),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b), .field(fld_b),
        .frame_start(fs_b), .frame_cnt(fc_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    vga_pattern_gen #(
        .H_DISP(16), .H_FPORCH(2), .H_SYNC(3), .H_BPORCH(3),
        .V_DISP(8), .V_FPORCH(1), .V_SYNC(2), .V_BPORCH(1),
        .HS_POLARITY(1'b1), .VS_POLARITY(1'b1), .FRAME_INTERLACED(1'b1),
        .COLOR_BITS(4), .CNT_BITS(12)
    ) u_dut_c (
        .clk(clk), .reset(reset), .en(en), .pattern_sel(pattern_sel),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c), .field(fld_c),
        .frame_start(fs_c), .frame_cnt(fc_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c)
    );

    int checks = 0;
    int errors = 0;

    trip_t exp_q [$];
    trip_t act_q [$];
    ovec_t ref_seq [$];

    int         st_h   [3];
    int         st_v   [3];
    logic       st_f   [3];
    logic [7:0] st_fc  [3];
    logic [2:0] st_pat [3];
    ovec_t      st_o   [3];

    // Reference model of one build: returns the outputs seen after the edge.
    function automatic ovec_t model(int i, logic rst_i, logic en_i, logic [2:0] sel);
        ovec_t      o;
        int         ht, vt, yv, bar;
        logic [2:0] pat, code;
        if (rst_i) begin
            st_h[i] = 0; st_v[i] = 0; st_f[i] = 1'b0; st_fc[i] = 8'd0; st_pat[i] = 3'd0;
            o = '0;
            o.hs = ~pol[i];
            o.vs = ~pol[i];
            st_o[i] = o;
            return o;
        end
        if (!en_i) return st_o[i];
        o   = st_o[i];
        ht  = hd[i] + HF + HSW + HB;
        vt  = VD + VF + VSW + VB + ((il[i] && st_f[i]) ? 1 : 0);
        yv  = il[i] ? 2 * st_v[i] + int'(st_f[i]) : st_v[i];
        pat = (st_h[i] == 0 && st_v[i] == 0) ? sel : st_pat[i];
        o.hs  = (st_h[i] >= hd[i] + HF && st_h[i] < hd[i] + HF + HSW) ? pol[i] : ~pol[i];
        o.vs  = (st_v[i] >= VD + VF && st_v[i] < VD + VF + VSW) ? pol[i] : ~pol[i];
        o.de  = (st_h[i] < hd[i]) && (st_v[i] < VD);
        o.fld = st_f[i];
        o.fs  = o.de && st_h[i] == 0 && st_v[i] == 0;
        o.fc  = st_fc[i];
        o.r = 4'h0; o.g = 4'h0; o.b = 4'h0;
        if (o.de) begin
            o.x = 12'(st_h[i]);
            o.y = 12'(yv);
            case (pat)
                3'd0: begin
                    bar = st_h[i] / (hd[i] / 8);
                    if (bar > 7) bar = 7;
                    code = 3'(7 - bar);
                    o.r = code[1] ? 4'hF : 4'h0;
                    o.g = code[2] ? 4'hF : 4'h0;
                    o.b = code[0] ? 4'hF : 4'h0;
                end
                3'd1: begin
                    o.r = 4'((st_h[i] >> 4) & 15); o.g = o.r; o.b = o.r;
                end
                3'd2: if ((((st_h[i] >> 3) ^ (yv >> 3)) & 1) == 1) begin
                    o.r = 4'hF; o.g = 4'hF; o.b = 4'hF;
                end
                3'd3: if (st_h[i] % 16 == 0 || yv % 16 == 0 || st_h[i] == hd[i] - 1 || st_v[i] == VD - 1) begin
                    o.r = 4'hF; o.g = 4'hF; o.b = 4'hF;
                end
                3'd4: begin
                    o.r = st_fc[i][3:0]; o.g = o.r; o.b = o.r;
                end
                default: ;
            endcase
        end
        if (st_h[i] == 0 && st_v[i] == 0) st_pat[i] = sel;
        if (st_h[i] == ht - 1) begin
            st_h[i] = 0;
            if (st_v[i] == vt - 1) begin
                st_v[i] = 0;
                if (!il[i] || st_f[i]) st_fc[i] = st_fc[i] + 8'd1;
                st_f[i] = il[i] & ~st_f[i];
            end else begin
                st_v[i] = st_v[i] + 1;
            end
        end else begin
            st_h[i] = st_h[i] + 1;
        end
        st_o[i] = o;
        return o;
    endfunction

    task automatic step(input logic rst_i, input logic en_i, input logic [2:0] sel_i);
        trip_t e, a;
        reset       = rst_i;
        en          = en_i;
        pattern_sel = sel_i;
        e.a = model(0, rst_i, en_i, sel_i);
        e.b = model(1, rst_i, en_i, sel_i);
        e.c = model(2, rst_i, en_i, sel_i);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.a = {hs_a, vs_a, de_a, x_a, y_a, fld_a, fs_a, fc_a, r_a, g_a, b_a};
        a.b = {hs_b, vs_b, de_b, x_b, y_b, fld_b, fs_b, fc_b, r_b, g_b, b_b};
        a.c = {hs_c, vs_c, de_c, x_c, y_c, fld_c, fs_c, fc_c, r_c, g_c, b_c};
        act_q.push_back(a);
    endtask

    task automatic test_reset();
        trip_t e, a;
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 3'd0);
        checks++;
        if (hs_a !== 1'b1 || vs_a !== 1'b1 || hs_c !== 1'b0 || vs_c !== 1'b0 ||
            de_a !== 1'b0 || x_a !== 12'd0 || fc_a !== 8'd0 || r_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_levels hs_a=%b vs_a=%b hs_c=%b vs_c=%b de=%b x=%0d fc=%0d r=%h want 1 1 0 0 0 0 0 0",
                     hs_a, vs_a, hs_c, vs_c, de_a, x_a, fc_a, r_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_sb act=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_timing();
        trip_t e, a;
        int n = 0, hs_lo = 0, vs_lo = 0, de_hi = 0, hs_hi_c = 0;
        repeat (576) step(1'b0, 1'b1, 3'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n++;
            checks++;
            if (a !== e) begin errors++; $display("FAIL timing_sb n=%0d act=%h exp=%h", n, a, e); end
            if (n <= 288) begin
                ref_seq.push_back(a.a);
                if (!a.a.hs) hs_lo++;
                if (!a.a.vs) vs_lo++;
                if (a.a.de)  de_hi++;
                if (a.c.hs)  hs_hi_c++;
            end
            if (n == 1) begin
                checks++;
                if (!(a.a.fs && a.a.x == 12'd0 && a.a.r == 4'hF && a.a.g == 4'hF && a.a.b == 4'hF)) begin
                    errors++;
                    $display("FAIL first_bar fs=%b x=%0d rgb=%h%h%h want fs=1 x=0 rgb=FFF", a.a.fs, a.a.x, a.a.r, a.a.g, a.a.b);
                end
            end
        end
        checks++;
        if (hs_lo != 36 || vs_lo != 48 || de_hi != 128) begin
            errors++;
            $display("FAIL frame_counts hs_lo=%0d vs_lo=%0d de=%0d want 36 48 128", hs_lo, vs_lo, de_hi);
        end
        checks++;
        if (hs_hi_c != 36) begin errors++; $display("FAIL polarity_c hs_high=%0d want 36", hs_hi_c); end
    endtask

    task automatic test_color_bars();
        trip_t e, a;
        int n = 0;
        step(1'b1, 1'b1, 3'd0);
        repeat (28) step(1'b0, 1'b1, 3'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n++;
            checks++;
            if (a !== e) begin errors++; $display("FAIL bars_sb n=%0d act=%h exp=%h", n, a, e); end
            if (a.b.de && a.b.x >= 12'd16 && n > 1) begin
                checks++;
                if ({a.b.r, a.b.g, a.b.b} !== 12'h000) begin
                    errors++; $display("FAIL bar7_tail x=%0d rgb=%h want 000", a.b.x, {a.b.r, a.b.g, a.b.b});
                end
            end
            if (a.b.de && (a.b.x == 12'd2 || a.b.x == 12'd3) && n > 1) begin
                checks++;
                if ({a.b.r, a.b.g, a.b.b} !== 12'hFF0) begin
                    errors++; $display("FAIL bar1_yellow x=%0d rgb=%h want FF0", a.b.x, {a.b.r, a.b.g, a.b.b});
                end
            end
        end
    endtask

    task automatic test_interlace();
        trip_t e, a;
        int n = 0, fs_cnt = 0;
        step(1'b1, 1'b1, 3'd0);
        repeat (601) step(1'b0, 1'b1, 3'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n++;
            checks++;
            if (a !== e) begin errors++; $display("FAIL interlace_sb n=%0d act=%h exp=%h", n, a, e); end
            if (n >= 2 && n <= 601 && a.c.fs) fs_cnt++;
            if (n == 290) begin
                checks++;
                if (!(a.c.fs && a.c.fld && a.c.y == 12'd1)) begin
                    errors++; $display("FAIL field1_start fs=%b fld=%b y=%0d want 1 1 1", a.c.fs, a.c.fld, a.c.y);
                end
            end
            if (n == 601 || n == 602) begin
                checks++;
                if (a.c.fc !== ((n == 601) ? 8'd0 : 8'd1)) begin
                    errors++; $display("FAIL interlace_fcnt n=%0d got=%0d want=%0d", n, a.c.fc, (n == 601) ? 0 : 1);
                end
            end
        end
        checks++;
        if (fs_cnt != 2) begin errors++; $display("FAIL fs_per_frame got=%0d want 2", fs_cnt); end
    endtask

    task automatic test_pattern_switch();
        trip_t e, a;
        int n = 0;
        step(1'b1, 1'b1, 3'd0);
        repeat (100) step(1'b0, 1'b1, 3'd0);
        repeat (220) step(1'b0, 1'b1, 3'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n++;
            checks++;
            if (a !== e) begin errors++; $display("FAIL switch_sb n=%0d act=%h exp=%h", n, a, e); end
            if (n == 122) begin
                checks++;
                if (a.a.r !== 4'hF) begin errors++; $display("FAIL bars_hold r=%h want F", a.a.r); end
            end
            if (n == 298) begin
                checks++;
                if (!(a.a.x == 12'd8 && a.a.y == 12'd0 && {a.a.r, a.a.g, a.a.b} == 12'hFFF)) begin
                    errors++; $display("FAIL checker_start x=%0d y=%0d rgb=%h want 8 0 FFF", a.a.x, a.a.y, {a.a.r, a.a.g, a.a.b});
                end
            end
        end
    endtask

    task automatic test_patterns();
        trip_t e, a;
        logic [2:0] sels [4] = '{3'd1, 3'd3, 3'd4, 3'd5};
        for (int p = 0; p < 4; p++) begin
            int n = 0;
            step(1'b1, 1'b1, sels[p]);
            repeat ((sels[p] == 3'd4) ? 600 : 300) step(1'b0, 1'b1, sels[p]);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); a = act_q.pop_front(); n++;
                checks++;
                if (a !== e) begin errors++; $display("FAIL pattern%0d_sb n=%0d act=%h exp=%h", sels[p], n, a, e); end
                if (sels[p] == 3'd3 && (n == 27 || n == 41)) begin
                    checks++;
                    if (a.a.r !== ((n == 27) ? 4'h0 : 4'hF)) begin
                        errors++; $display("FAIL crosshatch n=%0d r=%h want %h", n, a.a.r, (n == 27) ? 4'h0 : 4'hF);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        trip_t e, a;
        step(1'b1, 1'b1, 3'd0);
        repeat (82) step(1'b0, 1'b1, 3'd0);
        step(1'b1, 1'b1, 3'd0);
        checks++;
        if ({hs_a, vs_a, de_a, x_a, y_a, fs_a, fc_a, r_a} !== {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 8'd0, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset hs=%b vs=%b de=%b x=%0d y=%0d fs=%b fc=%0d r=%h want 1 1 0 0 0 0 0 0",
                     hs_a, vs_a, de_a, x_a, y_a, fs_a, fc_a, r_a);
        end
        step(1'b0, 1'b1, 3'd0);
        checks++;
        if (fs_a !== 1'b1 || de_a !== 1'b1 || fc_a !== 8'd0) begin
            errors++; $display("FAIL restart_fs fs=%b de=%b fc=%0d want 1 1 0", fs_a, de_a, fc_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_mid_sb act=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_en_toggle();
        trip_t e, a;
        int n = 0, idx = 0, hs_lo = 0;
        step(1'b1, 1'b1, 3'd0);
        for (int k = 0; k < 576; k++) step(1'b0, (k % 2 == 0), 3'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n++;
            checks++;
            if (a !== e) begin errors++; $display("FAIL en_toggle_sb n=%0d act=%h exp=%h", n, a, e); end
            if (n >= 2) begin
                if (!a.a.hs) hs_lo++;
                if (n % 2 == 0 && idx < ref_seq.size()) begin
                    checks++;
                    if (a.a !== ref_seq[idx]) begin
                        errors++; $display("FAIL en_sequence idx=%0d act=%h ref=%h", idx, a.a, ref_seq[idx]);
                    end
                    idx++;
                end
            end
        end
        checks++;
        if (hs_lo != 72 || idx != 288) begin
            errors++; $display("FAIL en_period hs_lo=%0d seq=%0d want 72 288", hs_lo, idx);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_color_bars();
        test_interlace();
        test_pattern_switch();
        test_patterns();
        test_reset_mid();
        test_en_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
